// File: rtl/mul_div_ctrl.sv
// rtl/mul_div_ctrl.sv - iterative 32x32 multiply / divide unit with HI/LO write-back
//
// Purpose: executes MULT/MULTU/DIV/DIVU one bit per cycle (radix-2 shift-add
// multiply, restoring shift-subtract divide) and writes HI/LO once at the end.
// Ports:
//   clk          sole clock, rising edge
//   rst          synchronous active-low reset
//   start        mul/div op presented in EX this cycle
//   op           00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a/src_b  multiplicand/multiplier or dividend/divisor
//   flush        abort in-flight op, suppress HI/LO write
//   stallreq     stall request toward EX and earlier stages
//   busy         FSM not in IDLE
//   hi_we/lo_we  HI/LO write enables (DONE only)
//   hi_out/lo_out HI/LO write data (DONE only, else 0)
//   div_by_zero  one-cycle flag in the DONE cycle of a divide by zero
module mul_div_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        stallreq,
  output logic        busy,
  output logic        hi_we,
  output logic        lo_we,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [31:0] opnd;     // multiplicand (MUL) or divisor (DIV) magnitude
  logic [63:0] acc;      // {hi, multiplier/product} or {remainder, quotient}
  logic        neg_lo;   // negate product (MUL) or quotient (DIV)
  logic        neg_hi;   // negate remainder (DIV)
  logic        is_div;
  logic        dbz;

  logic        is_signed;
  logic        src_b_zero;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic [63:0] mul_nxt;
  logic [32:0] div_top, div_diff;
  logic [63:0] div_nxt;
  logic [63:0] prod;
  logic [31:0] quo, rem;

  // op[0] == 0 selects the signed variants
  assign is_signed  = ~op[0];
  assign src_b_zero = (src_b == 32'd0);
  assign mag_a      = (is_signed && src_a[31]) ? (~src_a + 32'd1) : src_a;
  assign mag_b      = (is_signed && src_b[31]) ? (~src_b + 32'd1) : src_b;

  // Shift-add: add multiplicand into the upper half when the LSB of the
  // multiplier is set, then shift the whole 65-bit value right by one.
  assign mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
  assign mul_nxt = {mul_sum, acc[31:1]};

  // Restoring divide: shift remainder left with the next dividend bit; the
  // 33-bit compare covers remainders that briefly exceed 32 bits.
  assign div_top  = acc[63:31];
  assign div_diff = div_top - {1'b0, opnd};
  assign div_nxt  = div_diff[32] ? {div_top[31:0], acc[30:0], 1'b0}
                                 : {div_diff[31:0], acc[30:0], 1'b1};

  assign prod = neg_lo ? (~acc + 64'd1) : acc;
  assign quo  = neg_lo ? (~acc[31:0] + 32'd1) : acc[31:0];
  assign rem  = neg_hi ? (~acc[63:32] + 32'd1) : acc[63:32];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= 5'd0;
      opnd   <= 32'd0;
      acc    <= 64'd0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      is_div <= 1'b0;
      dbz    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (!flush) begin
        case (state)
          IDLE: begin
            if (start) begin
              cnt    <= 5'd0;
              is_div <= op[1];
              if (op[1] && src_b_zero) begin
                // Divide by zero: preload the fixed HI/LO result directly.
                acc    <= {src_a, 32'hFFFF_FFFF};
                opnd   <= 32'd0;
                neg_lo <= 1'b0;
                neg_hi <= 1'b0;
                dbz    <= 1'b1;
              end else begin
                acc    <= {32'd0, (op[1] ? mag_a : mag_b)};
                opnd   <= op[1] ? mag_b : mag_a;
                neg_lo <= is_signed & (src_a[31] ^ src_b[31]);
                neg_hi <= is_signed & src_a[31];
                dbz    <= 1'b0;
              end
            end
          end
          MUL: begin
            acc <= mul_nxt;
            cnt <= (cnt == 5'd31) ? cnt : cnt + 5'd1;
          end
          DIV: begin
            acc <= div_nxt;
            cnt <= (cnt == 5'd31) ? cnt : cnt + 5'd1;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    stallreq    = 1'b0;
    hi_we       = 1'b0;
    lo_we       = 1'b0;
    hi_out      = 32'd0;
    lo_out      = 32'd0;
    div_by_zero = 1'b0;
    busy        = (state != IDLE);
    case (state)
      IDLE: begin
        if (start && !flush) begin
          stallreq  = 1'b1;
          state_nxt = op[1] ? (src_b_zero ? DONE : DIV) : MUL;
        end
      end
      MUL: begin
        stallreq = 1'b1;
        if (cnt == 5'd31) state_nxt = DONE;
      end
      DIV: begin
        stallreq = 1'b1;
        if (cnt == 5'd31) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
        hi_out    = is_div ? rem : prod[63:32];
        lo_out    = is_div ? quo : prod[31:0];
        if (!flush) begin
          hi_we       = 1'b1;
          lo_we       = 1'b1;
          div_by_zero = dbz;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

endmodule

// File: doc/mul_div_ctrl.md
MUL_DIV_CTRL -- requirements
Module: mul_div_ctrl

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port start  input  1  valid mul/div op presented in EX this cycle.
REQ-004 SHALL have port op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have port src_a  input  32  multiplicand / dividend.
REQ-006 SHALL have port src_b  input  32  multiplier / divisor.
REQ-007 SHALL have port flush  input  1  abort in-flight op; no HI/LO write.
REQ-008 SHALL have port stallreq  output  1  request to stall the EX stage and earlier stages.
REQ-009 SHALL have port busy  output  1  FSM not in IDLE.
REQ-010 SHALL have ports hi_we, lo_we  output  1 each  HI/LO write enables toward the HI/LO register file.
REQ-011 SHALL have ports hi_out, lo_out  output  32 each  HI/LO write data.
REQ-012 SHALL have port div_by_zero  output  1  one-cycle flag for a DIV/DIVU with src_b == 0.

Function
REQ-013 SHALL implement FSM states IDLE, MUL, DIV, DONE; busy = (state != IDLE).
REQ-014 IDLE, start=1 (cycle T): SHALL latch magnitudes of src_a/src_b (absolute value for MULT/DIV, raw for unsigned), result-sign info, and op; SHALL clear the 5-bit iteration counter; SHALL go to MUL (op[1]=0) or DIV (op[1]=1).
REQ-015 stallreq SHALL be combinationally 1 in cycle T (IDLE and start) and in every MUL/DIV cycle; SHALL be 0 in IDLE without start and in DONE.
REQ-016 MUL: SHALL perform one radix-2 shift-add step per cycle over a 64-bit accumulator, 32 cycles (T+1..T+32), then go to DONE.
REQ-017 DIV: SHALL perform one restoring shift-subtract step per cycle over a 64-bit remainder/quotient register, 32 cycles (T+1..T+32), then go to DONE.
REQ-018 Counter SHALL increment once per MUL/DIV cycle; the exit transition SHALL occur on the cycle where counter == 31; no wrap past 31.
REQ-019 DONE (T+33): SHALL assert hi_we=lo_we=1 for exactly one cycle with final data, then return to IDLE.
REQ-020 MULT/MULTU results: hi_out = product[63:32], lo_out = product[31:0]; MULT SHALL negate the 64-bit product when the operand signs differ.
REQ-021 DIV/DIVU results: lo_out = quotient, hi_out = remainder; DIV quotient SHALL be negated when the operand signs differ; remainder SHALL take the sign of the dividend.
REQ-022 Divide by zero (DIV/DIVU, src_b == 0 at T): SHALL skip iterations and go IDLE -> DONE at T+1; hi_out = src_a, lo_out = 32'hFFFFFFFF; div_by_zero = 1 in that DONE cycle only.
REQ-023 start SHALL be ignored while in MUL, DIV or DONE.
REQ-024 flush=1 in any state SHALL force IDLE next cycle, with hi_we/lo_we = 0 in that cycle and the next; flush SHALL take priority over start and over DONE writes.
REQ-025 Outside DONE, hi_we, lo_we and div_by_zero SHALL be 0, and hi_out/lo_out SHALL be 0.
REQ-026 Signed edge case 0x80000000 / 0xFFFFFFFF (DIV) SHALL yield lo_out = 32'h80000000, hi_out = 0 (no trap).

Reset
REQ-027 rst=0 at a rising edge SHALL force IDLE, counter=0, internal operand/accumulator registers=0, and all outputs 0, regardless of state (including mid-operation).
REQ-028 rst SHALL have priority over flush and start; the first start accepted is the one sampled on the first edge with rst=1.

Verification
REQ-029 MULTU src_a=32'hFFFFFFFF, src_b=2 at T -> stallreq=1 for T..T+32; at T+33 hi_we=lo_we=1, hi_out=1, lo_out=32'hFFFFFFFE.
REQ-030 MULT src_a=-3 (32'hFFFFFFFD), src_b=5 -> at T+33 hi_out=32'hFFFFFFFF, lo_out=32'hFFFFFFF1.
REQ-031 DIV src_a=-7, src_b=2 -> at T+33 lo_out=32'hFFFFFFFD (-3), hi_out=32'hFFFFFFFF (-1); DIVU 100/7 -> lo_out=14, hi_out=2.
REQ-032 DIVU src_a=7, src_b=0 -> stallreq=1 only at T; at T+1 div_by_zero=1, hi_out=7, lo_out=32'hFFFFFFFF, writes asserted.
REQ-033 MULT started at T, flush=1 at T+10 -> IDLE and stallreq=0 at T+11; no hi_we/lo_we pulse through T+40; a new start at T+12 completes at T+45.
REQ-034 DIV started at T, rst=0 at T+5 -> all outputs 0 from T+6; no write pulse; start at T+8 with rst=1 is accepted normally.
